fifo_stream_reader: RTL and testbench

- Read-side consumer for the team's synchronous FIFO (registered read data, separate empty flag).
- Issues FIFO read enables, captures the read data one cycle later, and presents it on a valid/ready stream output with full throughput.
- A 2-entry output buffer absorbs the FIFO read latency and downstream backpressure, so no word is lost or duplicated.
- Sits between a FIFO instance and any stream consumer (UART TX, packetiser, etc.).

---
 rtl/fifo_stream_reader_if.sv | 32 +++
 rtl/fifo_stream_reader.sv | 103 ++++++++++
 tb/tb_fifo_stream_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader_if
// Purpose  : FIFO read-side and stream-side signals of fifo_stream_reader.
// Revision : 1.0
// ============================================================================
interface fifo_stream_reader_if #(
   parameter int WORD_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  enable_in;
   logic                  fifo_empty_in;
   logic [WORD_WIDTH-1:0] fifo_data_in;
   logic                  fifo_rd_en_out;
   logic                  vld_out;
   logic                  rdy_in;
   logic [WORD_WIDTH-1:0] data_out;
   logic                  last_out;
   logic [CNT_WIDTH-1:0]  word_cnt_out;
   logic                  idle_out;

   modport master (
      input  enable_in, fifo_empty_in, fifo_data_in, rdy_in,
      output fifo_rd_en_out, vld_out, data_out, last_out, word_cnt_out, idle_out
   );

   modport slave (
      output enable_in, fifo_empty_in, fifo_data_in, rdy_in,
      input  fifo_rd_en_out, vld_out, data_out, last_out, word_cnt_out, idle_out
   );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Reads a registered-output FIFO into a 2-entry valid/ready buffer.
//            Optional burst marker on last_out via macro FIFO_RD_LAST_EN.
// Revision : 1.0
// ============================================================================
module fifo_stream_reader #(
   parameter int WORD_WIDTH = 8,
   parameter int CNT_WIDTH  = 16,
   parameter int BURST_LEN  = 4
) (
   input wire                  clk_in,
   input wire                  reset_in,
   fifo_stream_reader_if.master bus
);

   if (BURST_LEN < 1) begin : g_burst_len_check
      $error("BURST_LEN must be at least 1");
   end

   logic [1:0]            count_q, count_d;
   logic                  inflight_q, inflight_d;
   logic [WORD_WIDTH-1:0] buf0_q, buf0_d;
   logic [WORD_WIDTH-1:0] buf1_q, buf1_d;
   logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
   logic                  pop;
   logic                  rd_en;
   logic [1:0]            count_pop;

   always_comb begin
      pop       = (count_q != 2'd0) & bus.rdy_in;
      // rdy_in reaches rd_en combinationally so a full buffer can still read each cycle
      rd_en     = reset_in & bus.enable_in & ~bus.fifo_empty_in &
                  (((({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2)) | pop);
      count_pop = count_q - {1'b0, pop};
      buf0_d    = buf0_q;
      buf1_d    = buf1_q;
      if (pop) begin
         buf0_d = buf1_q;
      end
      if (inflight_q) begin
         if (count_pop == 2'd0) begin
            buf0_d = bus.fifo_data_in;
         end else begin
            buf1_d = bus.fifo_data_in;
         end
      end
      count_d    = count_pop + {1'b0, inflight_q};
      inflight_d = rd_en;
      word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         word_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         inflight_q <= inflight_d;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         word_cnt_q <= word_cnt_d;
      end
   end

`ifdef FIFO_RD_LAST_EN
   localparam int                 BURST_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LEN - 1);

   logic [BURST_W-1:0] burst_q, burst_d;

   always_comb begin
      burst_d = burst_q;
      if (pop) begin
         burst_d = (burst_q == BURST_MAX) ? '0 : burst_q + BURST_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end

   assign bus.last_out = (count_q != 2'd0) & (burst_q == BURST_MAX);
`else
   assign bus.last_out = 1'b0;
`endif

   assign bus.fifo_rd_en_out = rd_en;
   assign bus.vld_out        = (count_q != 2'd0);
   assign bus.data_out       = buf0_q;
   assign bus.word_cnt_out   = word_cnt_q;
   assign bus.idle_out       = (count_q == 2'd0) & ~inflight_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Self-checking bench for fifo_stream_reader with a FIFO model.
// Revision : 1.0
// ============================================================================
module tb_fifo_stream_reader;
   localparam int WW = 8;
   localparam int CW = 16;
   localparam int BL = 4;
`ifdef FIFO_RD_LAST_EN
   localparam bit LAST_EN = 1'b1;
`else
   localparam bit LAST_EN = 1'b0;
`endif

   logic clk_in = 1'b0;
   logic reset_in;

   fifo_stream_reader_if #(.WORD_WIDTH(WW), .CNT_WIDTH(CW)) bus();

   fifo_stream_reader #(.WORD_WIDTH(WW), .CNT_WIDTH(CW), .BURST_LEN(BL)) dut (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   int            n_cmp = 0;
   int            n_fail = 0;
   logic          wr_en;
   logic [WW-1:0] wr_data;
   logic [WW-1:0] fifo_q[$];
   logic [WW-1:0] sb[$];
   int            outst = 0;
   int            acc_last = 0;
   int            burst_pos = 0;
   logic [CW-1:0] exp_wcnt = '0;
   bit            stall_prev = 1'b0;
   logic [WW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   int            cyc = 0;
   int            acc_total = 0;
   int            deliv_total = 0;
   int            last_total = 0;
   int            first_acc = -1;
   int            first_pop = -1;
   int            last_pop = -1;

   typedef struct {
      logic [WW-1:0] base;
      int            n;
      logic [7:0]    rdy_pat;
      int            en_stop;
      int            exp_deliv;
      int            exp_left;
      int            exp_last;
      bit            chk_span;
   } vec_t;

   vec_t vt[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: check outputs mid-cycle, advance the model, then update the FIFO at the edge.
   task automatic step();
      bit pop_m, acc_m, act_acc, exp_vld, exp_last, exp_rd;
      @(negedge clk_in);
      exp_vld  = (outst - acc_last) > 0;
      pop_m    = exp_vld && bus.rdy_in;
      exp_rd   = reset_in && bus.enable_in && !bus.fifo_empty_in && ((outst < 2) || pop_m);
      acc_m    = exp_rd;
      act_acc  = bus.fifo_rd_en_out && !bus.fifo_empty_in;
      exp_last = LAST_EN && exp_vld && (burst_pos == BL - 1);
      check("rd_en", 32'(bus.fifo_rd_en_out), 32'(exp_rd));
      check("vld", 32'(bus.vld_out), 32'(exp_vld));
      check("idle", 32'(bus.idle_out), 32'(outst == 0));
      check("word_cnt", 32'(bus.word_cnt_out), 32'(exp_wcnt));
      check("last", 32'(bus.last_out), 32'(exp_last));
      if (stall_prev) begin
         check("hold_data", 32'(bus.data_out), 32'(prev_data));
         check("hold_last", 32'(bus.last_out), 32'(prev_last));
      end
      if (pop_m) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL data: got 0x%0h, want nothing (cycle %0d)", bus.data_out, cyc);
         end else begin
            if (bus.data_out !== sb[0]) begin
               n_fail++;
               $display("FAIL data: got 0x%0h, want 0x%0h (cycle %0d)", bus.data_out, sb[0], cyc);
            end
            void'(sb.pop_front());
         end
      end
      if (!reset_in) begin
         outst      = 0;
         acc_last   = 0;
         burst_pos  = 0;
         exp_wcnt   = '0;
         stall_prev = 1'b0;
         sb.delete();
      end else begin
         if (acc_m && fifo_q.size() > 0) sb.push_back(fifo_q[0]);
         outst    = outst + int'(acc_m) - int'(pop_m);
         acc_last = int'(acc_m);
         if (pop_m) begin
            exp_wcnt  = exp_wcnt + 1'b1;
            burst_pos = (burst_pos + 1) % BL;
            deliv_total++;
            if (bus.last_out) last_total++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         if (acc_m) begin
            acc_total++;
            if (first_acc < 0) first_acc = cyc;
         end
         stall_prev = exp_vld && !bus.rdy_in;
         prev_data  = bus.data_out;
         prev_last  = bus.last_out;
      end
      @(posedge clk_in);
      if (!reset_in) begin
         fifo_q.delete();
         bus.fifo_empty_in <= 1'b1;
         bus.fifo_data_in  <= '0;
      end else begin
         if (act_acc && fifo_q.size() > 0) bus.fifo_data_in <= fifo_q.pop_front();
         if (wr_en) fifo_q.push_back(wr_data);
         bus.fifo_empty_in <= (fifo_q.size() == 0);
      end
      cyc++;
      #2;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;
      int idx, d0, l0, a0;

      vt[0] = '{8'h11, 8,  8'hFF, -1, 8,  0,  LAST_EN ? 2 : 0, 1'b1};
      vt[1] = '{8'h01, 6,  8'hE9, -1, 6,  0,  LAST_EN ? 1 : 0, 1'b0};
      vt[2] = '{8'hA0, 16, 8'hFF,  3, 3,  13, 0,               1'b0};
      vt[3] = '{8'h30, 10, 8'hFF, -1, 10, 0,  LAST_EN ? 2 : 0, 1'b1};

      reset_in          = 1'b0;
      bus.enable_in     = 1'b0;
      bus.rdy_in        = 1'b0;
      bus.fifo_empty_in = 1'b1;
      bus.fifo_data_in  = '0;
      wr_en             = 1'b0;
      wr_data           = '0;

      for (int v = 0; v < 4; v++) begin
         reset_in      = 1'b0;
         bus.enable_in = 1'b0;
         bus.rdy_in    = 1'b0;
         wr_en         = 1'b0;
         repeat (3) step();
         reset_in      = 1'b1;
         bus.enable_in = 1'b1;
         #1;
         check("rst_vld", 32'(bus.vld_out), 32'd0);
         check("rst_rd_en", 32'(bus.fifo_rd_en_out), 32'd0);
         check("rst_idle", 32'(bus.idle_out), 32'd1);
         check("rst_word_cnt", 32'(bus.word_cnt_out), 32'd0);
         check("rst_data", 32'(bus.data_out), 32'd0);
         check("rst_last", 32'(bus.last_out), 32'd0);

         idx = 0; a0 = acc_total; d0 = deliv_total; l0 = last_total;
         first_acc = -1; first_pop = -1; last_pop = -1; done = 1'b0;
         for (int c = 0; c < 300 && !done; c++) begin
            wr_en   = (idx < vt[v].n);
            wr_data = vt[v].base + WW'(idx);
            if (wr_en) idx++;
            bus.rdy_in    = vt[v].rdy_pat[c % 8];
            bus.enable_in = !(vt[v].en_stop >= 0 && (acc_total - a0) >= vt[v].en_stop);
            step();
            done = (idx == vt[v].n) && (deliv_total - d0 >= vt[v].exp_deliv) && (outst == 0);
         end
         wr_en = 1'b0;
         check("scenario_done", 32'(done), 32'd1);
         bus.rdy_in = 1'b1;
         repeat (4) step();
         check("delivered", 32'(deliv_total - d0), 32'(vt[v].exp_deliv));
         check("fifo_left", 32'(fifo_q.size()), 32'(vt[v].exp_left));
         check("word_cnt_end", 32'(bus.word_cnt_out), 32'(vt[v].exp_deliv));
         check("idle_end", 32'(bus.idle_out), 32'd1);
         check("last_count", 32'(last_total - l0), 32'(vt[v].exp_last));
         if (vt[v].chk_span) begin
            check("span", 32'(last_pop - first_pop), 32'(vt[v].exp_deliv - 1));
            check("latency", 32'(first_pop - first_acc), 32'd2);
         end
      end

      // Mid-operation reset with a full, stalled buffer.
      reset_in = 1'b0;
      repeat (2) step();
      reset_in = 1'b1; bus.enable_in = 1'b1; bus.rdy_in = 1'b1;
      idx = 0; d0 = deliv_total;
      for (int c = 0; c < 40 && (deliv_total - d0) < 2; c++) begin
         wr_en = (idx < 6); wr_data = 8'h50 + WW'(idx);
         if (wr_en) idx++;
         step();
      end
      bus.rdy_in = 1'b0;
      for (int c = 0; c < 40 && !(outst == 2 && acc_last == 0); c++) begin
         wr_en = (idx < 6); wr_data = 8'h50 + WW'(idx);
         if (wr_en) idx++;
         step();
      end
      wr_en = 1'b0;
      #1;
      check("pre_rst_vld", 32'(bus.vld_out), 32'd1);
      check("pre_rst_word_cnt", 32'(bus.word_cnt_out), 32'd2);
      reset_in = 1'b0;
      step();
      reset_in = 1'b1;
      #1;
      check("mid_rst_vld", 32'(bus.vld_out), 32'd0);
      check("mid_rst_word_cnt", 32'(bus.word_cnt_out), 32'd0);
      check("mid_rst_idle", 32'(bus.idle_out), 32'd1);
      check("mid_rst_data", 32'(bus.data_out), 32'd0);
      check("mid_rst_last", 32'(bus.last_out), 32'd0);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         reset_in      = ($urandom_range(0, 149) != 0);
         bus.enable_in = ($urandom_range(0, 9) != 0);
         bus.rdy_in    = ($urandom_range(0, 1) != 0);
         wr_en         = ($urandom_range(0, 2) != 0);
         wr_data       = WW'($urandom);
         step();
      end
      reset_in = 1'b1; bus.enable_in = 1'b1; bus.rdy_in = 1'b1; wr_en = 1'b0;
      for (int c = 0; c < 600 && !(fifo_q.size() == 0 && outst == 0); c++) begin
         step();
      end
      repeat (3) step();
      check("drain_idle", 32'(bus.idle_out), 32'd1);
      check("drain_sb", 32'(sb.size()), 32'd0);
      check("drain_fifo", 32'(fifo_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
